// File: rtl/pipe_flow_pkg.sv
// Shared constants for the pipeline flow controller.
//   - state_t / ST_* : 2-bit FSM state encoding
//   - DIV_TIMEOUT_DEF: default divider watchdog length in cycles
//   - REG_X0         : architectural zero register index
package pipe_flow_pkg;

   localparam int DIV_TIMEOUT_DEF = 40;

   localparam logic [4:0] REG_X0 = 5'd0;

   typedef logic [1:0] state_t;

   localparam state_t ST_RUN       = 2'd0;
   localparam state_t ST_DIV_WAIT  = 2'd1;
   localparam state_t ST_IRQ_DRAIN = 2'd2;
   localparam state_t ST_IRQ_JUMP  = 2'd3;

endpackage

// File: rtl/pipe_flow_ctrl_hazard_unit.sv
// Load-use hazard detector.
// Ports:
//   ex_is_load_i             : instruction in EX is a load
//   ex_rd_i                  : destination register of the EX instruction
//   id_rs1_i, id_rs2_i       : source registers of the ID instruction
//   id_rs1_used_i/rs2_used_i : source register is actually read
//   load_use_o               : ID needs a value the EX load has not produced yet
module pipe_flow_ctrl_hazard_unit
   import pipe_flow_pkg::*;
(
   input  logic       ex_is_load_i,
   input  logic [4:0] ex_rd_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_rs1_used_i,
   input  logic       id_rs2_used_i,
   output logic       load_use_o
);

   logic rs1_hit_s;
   logic rs2_hit_s;

   assign rs1_hit_s = id_rs1_used_i && (id_rs1_i == ex_rd_i);
   assign rs2_hit_s = id_rs2_used_i && (id_rs2_i == ex_rd_i);

   // x0 is never actually written, so a load targeting it creates no hazard
   assign load_use_o = ex_is_load_i && (ex_rd_i != REG_X0) && (rs1_hit_s || rs2_hit_s);

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Central pipeline flow controller for the 5-stage RV32I core.
// Merges EX redirects, load-use hazards, data-bus wait, divider sequencing
// and interrupt entry into per-stage stall/flush and one redirect to pc_reg.
// Ports:
//   jump_en_i/jump_addr_i     : EX taken branch/jump and target
//   ex_is_load_i, ex_rd_i     : EX load info for load-use detection
//   id_rs*_i, id_rs*_used_i   : ID source registers and usage
//   id_pc_i                   : PC held in IF/ID (resume point on interrupt)
//   div_start_i, div_done_i   : divider issue / result-valid pulse
//   mem_busy_i                : data bus not ready
//   irq_req_i, irq_addr_i     : pending interrupt and trap vector
//   jump_en_o, jump_addr_o    : redirect to pc_reg
//   stall_*_o, flush_*_o      : per-stage hold / bubble controls
//   irq_ack_o, irq_epc_o      : interrupt taken pulse and latched resume PC
//   div_timeout_o             : sticky divider watchdog flag
module pipe_flow_ctrl
   import pipe_flow_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            jump_en_i,
   input  logic [XLEN-1:0] jump_addr_i,
   input  logic            ex_is_load_i,
   input  logic [4:0]      ex_rd_i,
   input  logic [4:0]      id_rs1_i,
   input  logic [4:0]      id_rs2_i,
   input  logic            id_rs1_used_i,
   input  logic            id_rs2_used_i,
   input  logic [XLEN-1:0] id_pc_i,
   input  logic            div_start_i,
   input  logic            div_done_i,
   input  logic            mem_busy_i,
   input  logic            irq_req_i,
   input  logic [XLEN-1:0] irq_addr_i,
   output logic            jump_en_o,
   output logic [XLEN-1:0] jump_addr_o,
   output logic            stall_pc_o,
   output logic            stall_if_id_o,
   output logic            stall_id_ex_o,
   output logic            flush_if_id_o,
   output logic            flush_id_ex_o,
   output logic            irq_ack_o,
   output logic [XLEN-1:0] irq_epc_o,
   output logic            div_timeout_o
);

   localparam int CNT_W = $clog2(DIV_TIMEOUT) + 1;

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic              timeout_r, timeout_s;
   logic [XLEN-1:0]   vec_r, vec_s;
   logic [XLEN-1:0]   epc_r, epc_s;

   logic              load_use_s;
   logic              jump_s, stall_pc_s, stall_if_id_s, stall_id_ex_s;
   logic              flush_if_id_s, flush_id_ex_s, ack_s;
   logic [XLEN-1:0]   jump_addr_s;

   pipe_flow_ctrl_hazard_unit u_hazard (
      .ex_is_load_i  (ex_is_load_i),
      .ex_rd_i       (ex_rd_i),
      .id_rs1_i      (id_rs1_i),
      .id_rs2_i      (id_rs2_i),
      .id_rs1_used_i (id_rs1_used_i),
      .id_rs2_used_i (id_rs2_used_i),
      .load_use_o    (load_use_s)
   );

   // Next-state and raw control decode from current state and inputs
   always_comb begin
      state_s       = state_r;
      cnt_s         = cnt_r;
      timeout_s     = timeout_r;
      vec_s         = vec_r;
      epc_s         = epc_r;
      jump_s        = 1'b0;
      jump_addr_s   = jump_addr_i;
      stall_pc_s    = 1'b0;
      stall_if_id_s = 1'b0;
      stall_id_ex_s = 1'b0;
      flush_if_id_s = 1'b0;
      flush_id_ex_s = 1'b0;
      ack_s         = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (jump_en_i) begin
               // Redirect wins; a pending level irq is simply seen next cycle
               jump_s        = 1'b1;
               flush_if_id_s = 1'b1;
               flush_id_ex_s = 1'b1;
            end else if (mem_busy_i) begin
               stall_pc_s    = 1'b1;
               stall_if_id_s = 1'b1;
               stall_id_ex_s = 1'b1;
            end else if (div_start_i) begin
               stall_pc_s    = 1'b1;
               stall_if_id_s = 1'b1;
               stall_id_ex_s = 1'b1;
               cnt_s         = {CNT_W{1'b0}};
               state_s       = ST_DIV_WAIT;
            end else if (irq_req_i) begin
               vec_s         = irq_addr_i;
               epc_s         = id_pc_i;
               stall_pc_s    = 1'b1;
               stall_if_id_s = 1'b1;
               flush_id_ex_s = 1'b1;
               state_s       = ST_IRQ_DRAIN;
            end else if (load_use_s) begin
               stall_pc_s    = 1'b1;
               stall_if_id_s = 1'b1;
               flush_id_ex_s = 1'b1;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DIV_WAIT: begin
            // Saturating count so the watchdog can never wrap back to zero
            if (cnt_r != {CNT_W{1'b1}}) begin
               cnt_s = cnt_r + CNT_W'(1);
            end else begin
               cnt_s = cnt_r;
            end
            if (div_done_i) begin
               state_s = ST_RUN;
            end else if (cnt_r == CNT_W'(DIV_TIMEOUT - 1)) begin
               timeout_s = 1'b1;
               state_s   = ST_RUN;
            end else begin
               stall_pc_s    = 1'b1;
               stall_if_id_s = 1'b1;
               stall_id_ex_s = 1'b1;
            end
         end
         ST_IRQ_DRAIN: begin
            stall_pc_s    = 1'b1;
            stall_if_id_s = 1'b1;
            flush_id_ex_s = 1'b1;
            if (!mem_busy_i) begin
               state_s = ST_IRQ_JUMP;
            end else begin
               state_s = ST_IRQ_DRAIN;
            end
         end
         ST_IRQ_JUMP: begin
            jump_s        = 1'b1;
            jump_addr_s   = vec_r;
            flush_if_id_s = 1'b1;
            flush_id_ex_s = 1'b1;
            ack_s         = 1'b1;
            state_s       = ST_RUN;
         end
         default: begin
            state_s = ST_RUN;
         end
      endcase
   end

   // State, counter, watchdog flag and interrupt latches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_RUN;
         cnt_r     <= {CNT_W{1'b0}};
         timeout_r <= 1'b0;
         vec_r     <= {XLEN{1'b0}};
         epc_r     <= {XLEN{1'b0}};
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         timeout_r <= timeout_s;
         vec_r     <= vec_s;
         epc_r     <= epc_s;
      end
   end

   // Controls are forced low while reset is held; a flush always beats a stall
   assign jump_en_o     = rst_n & jump_s;
   assign jump_addr_o   = jump_addr_s;
   assign stall_pc_o    = rst_n & stall_pc_s;
   assign stall_if_id_o = rst_n & stall_if_id_s & ~flush_if_id_s;
   assign stall_id_ex_o = rst_n & stall_id_ex_s & ~flush_id_ex_s;
   assign flush_if_id_o = rst_n & flush_if_id_s;
   assign flush_id_ex_o = rst_n & flush_id_ex_s;
   assign irq_ack_o     = rst_n & ack_s;
   assign irq_epc_o     = epc_r;
   assign div_timeout_o = timeout_r;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed self-checking bench for pipe_flow_ctrl.
module tb_pipe_flow_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        jump_en_i = 1'b0;
   logic [31:0] jump_addr_i = 32'h0;
   logic        ex_is_load_i = 1'b0;
   logic [4:0]  ex_rd_i = 5'd0;
   logic [4:0]  id_rs1_i = 5'd0;
   logic [4:0]  id_rs2_i = 5'd0;
   logic        id_rs1_used_i = 1'b0;
   logic        id_rs2_used_i = 1'b0;
   logic [31:0] id_pc_i = 32'h0;
   logic        div_start_i = 1'b0;
   logic        div_done_i = 1'b0;
   logic        mem_busy_i = 1'b0;
   logic        irq_req_i = 1'b0;
   logic [31:0] irq_addr_i = 32'h0;
   logic        jump_en_o;
   logic [31:0] jump_addr_o;
   logic        stall_pc_o, stall_if_id_o, stall_id_ex_o;
   logic        flush_if_id_o, flush_id_ex_o;
   logic        irq_ack_o;
   logic [31:0] irq_epc_o;
   logic        div_timeout_o;

   int tests_run = 0;
   int tests_failed = 0;
   int stall_cnt;

   // {jump, stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, ack}
   logic [6:0] ctl;
   assign ctl = {jump_en_o, stall_pc_o, stall_if_id_o, stall_id_ex_o,
                 flush_if_id_o, flush_id_ex_o, irq_ack_o};

   localparam logic [6:0] C_ZERO  = 7'b0000000;
   localparam logic [6:0] C_LDUSE = 7'b0110010;
   localparam logic [6:0] C_JUMP  = 7'b1000110;
   localparam logic [6:0] C_HOLD  = 7'b0111000;
   localparam logic [6:0] C_IRQJ  = 7'b1000111;

   always #5 clk = ~clk;

   pipe_flow_ctrl #(.XLEN(32), .DIV_TIMEOUT(40)) dut (
      .clk(clk), .rst_n(rst_n),
      .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
      .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
      .id_pc_i(id_pc_i), .div_start_i(div_start_i), .div_done_i(div_done_i),
      .mem_busy_i(mem_busy_i), .irq_req_i(irq_req_i), .irq_addr_i(irq_addr_i),
      .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
      .stall_pc_o(stall_pc_o), .stall_if_id_o(stall_if_id_o),
      .stall_id_ex_o(stall_id_ex_o), .flush_if_id_o(flush_if_id_o),
      .flush_id_ex_o(flush_id_ex_o), .irq_ack_o(irq_ack_o),
      .irq_epc_o(irq_epc_o), .div_timeout_o(div_timeout_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change at the falling edge; checks happen 1 time unit later
   initial begin
      // Reset: controls must stay low even with active inputs
      jump_en_i = 1'b1; mem_busy_i = 1'b1;
      #1;
      chk("reset_ctl", {25'd0, ctl}, {25'd0, C_ZERO});
      chk("reset_epc", irq_epc_o, 32'h0);
      chk("reset_timeout", {31'd0, div_timeout_o}, 32'h0);
      @(negedge clk); @(negedge clk);
      jump_en_i = 1'b0; mem_busy_i = 1'b0; rst_n = 1'b1;
      #1 chk("idle_ctl", {25'd0, ctl}, {25'd0, C_ZERO});

      // Load-use: x5 loaded in EX, read as rs1 in ID
      @(negedge clk);
      ex_is_load_i = 1'b1; ex_rd_i = 5'd5; id_rs1_i = 5'd5; id_rs1_used_i = 1'b1;
      #1 chk("lduse_rs1", {25'd0, ctl}, {25'd0, C_LDUSE});
      @(negedge clk);
      ex_rd_i = 5'd0; id_rs1_i = 5'd0;
      #1 chk("lduse_x0", {25'd0, ctl}, {25'd0, C_ZERO});
      @(negedge clk);
      ex_rd_i = 5'd7; id_rs1_i = 5'd7; id_rs1_used_i = 1'b0;
      #1 chk("lduse_rs1_unused", {25'd0, ctl}, {25'd0, C_ZERO});
      @(negedge clk);
      id_rs2_i = 5'd7; id_rs2_used_i = 1'b1;
      #1 chk("lduse_rs2", {25'd0, ctl}, {25'd0, C_LDUSE});
      @(negedge clk);
      ex_is_load_i = 1'b0; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_rs2_used_i = 1'b0;
      mem_busy_i = 1'b1;
      #1 chk("mem_busy_run", {25'd0, ctl}, {25'd0, C_HOLD});

      // Jump with simultaneous irq: jump wins, irq taken next cycle
      @(negedge clk);
      mem_busy_i = 1'b0;
      jump_en_i = 1'b1; jump_addr_i = 32'h0000_0100;
      irq_req_i = 1'b1; irq_addr_i = 32'hAAAA_0000; id_pc_i = 32'h0000_0044;
      #1 chk("jump_ctl", {25'd0, ctl}, {25'd0, C_JUMP});
      chk("jump_addr", jump_addr_o, 32'h0000_0100);
      @(negedge clk);
      jump_en_i = 1'b0;
      #1 chk("irq_take_after_jump", {25'd0, ctl}, {25'd0, C_LDUSE});
      @(negedge clk);
      irq_req_i = 1'b0;  // dropping the request must not abort entry
      #1 chk("irq_drain_a", {25'd0, ctl}, {25'd0, C_LDUSE});
      @(negedge clk);
      #1 chk("irq_jump_a_ctl", {25'd0, ctl}, {25'd0, C_IRQJ});
      chk("irq_jump_a_addr", jump_addr_o, 32'hAAAA_0000);
      chk("irq_jump_a_epc", irq_epc_o, 32'h0000_0044);
      @(negedge clk);
      #1 chk("after_irq_a", {25'd0, ctl}, {25'd0, C_ZERO});

      // Interrupt with three busy drain cycles
      @(negedge clk);
      irq_req_i = 1'b1; irq_addr_i = 32'h8000_0000; id_pc_i = 32'h0000_0040;
      #1 chk("irq_take_b", {25'd0, ctl}, {25'd0, C_LDUSE});
      @(negedge clk);
      mem_busy_i = 1'b1; id_pc_i = 32'h0000_0999; jump_addr_i = 32'h0000_1234;
      stall_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         #1 if (ctl == C_LDUSE) stall_cnt++;
         if (i == 1) chk("drain_addr_passthru", jump_addr_o, 32'h0000_1234);
         @(negedge clk);
      end
      chk("drain_busy_cycles", stall_cnt, 32'd3);
      mem_busy_i = 1'b0; irq_req_i = 1'b0;
      #1 chk("drain_exit", {25'd0, ctl}, {25'd0, C_LDUSE});
      @(negedge clk);
      #1 chk("irq_jump_b_ctl", {25'd0, ctl}, {25'd0, C_IRQJ});
      chk("irq_jump_b_addr", jump_addr_o, 32'h8000_0000);
      chk("irq_jump_b_epc", irq_epc_o, 32'h0000_0040);
      @(negedge clk);
      #1 chk("after_irq_b", {25'd0, ctl}, {25'd0, C_ZERO});

      // Divide finishing after 33 stalled cycles; jump/irq ignored meanwhile
      @(negedge clk);
      div_start_i = 1'b1;
      #1 chk("div_start", {25'd0, ctl}, {25'd0, C_HOLD});
      @(negedge clk);
      div_start_i = 1'b0;
      stall_cnt = 0;
      for (int i = 0; i < 32; i++) begin
         if (i == 10) begin
            jump_en_i = 1'b1; irq_req_i = 1'b1;
            irq_addr_i = 32'h0000_0200; id_pc_i = 32'h0000_0080;
         end
         #1 if (ctl == C_HOLD) stall_cnt++;
         @(negedge clk);
      end
      chk("div_wait_stalls", stall_cnt, 32'd32);
      jump_en_i = 1'b0; div_done_i = 1'b1;
      #1 chk("div_done", {25'd0, ctl}, {25'd0, C_ZERO});
      @(negedge clk);
      div_done_i = 1'b0;
      #1 chk("irq_after_div", {25'd0, ctl}, {25'd0, C_LDUSE});
      @(negedge clk);
      irq_req_i = 1'b0;
      #1 chk("irq_drain_c", {25'd0, ctl}, {25'd0, C_LDUSE});
      @(negedge clk);
      #1 chk("irq_jump_c_ctl", {25'd0, ctl}, {25'd0, C_IRQJ});
      chk("irq_jump_c_addr", jump_addr_o, 32'h0000_0200);
      chk("irq_jump_c_epc", irq_epc_o, 32'h0000_0080);
      @(negedge clk);

      // Divide with no done: watchdog fires on the 40th wait cycle
      div_start_i = 1'b1;
      #1 chk("div2_start", {25'd0, ctl}, {25'd0, C_HOLD});
      @(negedge clk);
      div_start_i = 1'b0;
      stall_cnt = 0;
      for (int i = 0; i < 39; i++) begin
         #1 if (ctl == C_HOLD) stall_cnt++;
         @(negedge clk);
      end
      chk("div2_wait_stalls", stall_cnt, 32'd39);
      #1 chk("div2_timeout_cycle", {25'd0, ctl}, {25'd0, C_ZERO});
      chk("div2_flag_not_yet", {31'd0, div_timeout_o}, 32'h0);
      @(negedge clk);
      #1 chk("div2_flag_set", {31'd0, div_timeout_o}, 32'h1);
      chk("div2_back_run", {25'd0, ctl}, {25'd0, C_ZERO});
      @(negedge clk);
      div_start_i = 1'b1;
      #1 chk("div3_start_from_run", {25'd0, ctl}, {25'd0, C_HOLD});
      @(negedge clk);
      div_start_i = 1'b0; div_done_i = 1'b1;
      #1 chk("div3_done", {25'd0, ctl}, {25'd0, C_ZERO});
      @(negedge clk);
      div_done_i = 1'b0;
      #1 chk("timeout_sticky", {31'd0, div_timeout_o}, 32'h1);

      // Async reset while draining an interrupt
      @(negedge clk);
      irq_req_i = 1'b1; irq_addr_i = 32'h9000_0000; id_pc_i = 32'h0000_0050;
      #1 chk("irq_take_d", {25'd0, ctl}, {25'd0, C_LDUSE});
      @(negedge clk);
      irq_req_i = 1'b0; mem_busy_i = 1'b1;
      #1 chk("irq_drain_d", {25'd0, ctl}, {25'd0, C_LDUSE});
      #1 rst_n = 1'b0;
      #1 chk("rst_drain_ctl", {25'd0, ctl}, {25'd0, C_ZERO});
      chk("rst_drain_epc", irq_epc_o, 32'h0);
      chk("rst_drain_timeout", {31'd0, div_timeout_o}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1; mem_busy_i = 1'b0;
      #1 chk("post_rst_a", {25'd0, ctl}, {25'd0, C_ZERO});
      @(negedge clk);
      #1 chk("post_rst_b", {25'd0, ctl}, {25'd0, C_ZERO});
      @(negedge clk);
      ex_is_load_i = 1'b1; ex_rd_i = 5'd9; id_rs1_i = 5'd9; id_rs1_used_i = 1'b1;
      #1 chk("post_rst_run", {25'd0, ctl}, {25'd0, C_LDUSE});
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
- Central pipeline flow controller for the 5-stage RV32I core; a superset of the current jump/hold merge.
- Merges EX jumps, load-use hazards, data-bus wait, multi-cycle divide sequencing and CLINT interrupt entry.
- Produces per-stage stall/flush and the single redirect (jump) to pc_reg.
- Owns a small FSM that drains the pipe before interrupt entry and holds it during divides.

Parameters:
- XLEN, 32, address/data width.
- DIV_TIMEOUT, 40, maximum DIV_WAIT cycles before forced exit.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- jump_en_i  in  1  EX taken branch/jump
- jump_addr_i  in  XLEN  EX target
- ex_is_load_i  in  1  EX instruction is a load
- ex_rd_i  in  5  EX destination register
- id_rs1_i, id_rs2_i  in  5 each  ID source registers
- id_rs1_used_i, id_rs2_used_i  in  1 each  source actually read
- id_pc_i  in  XLEN  PC held in IF/ID
- div_start_i  in  1  EX issues DIV/REM
- div_done_i  in  1  divider result valid (one-cycle pulse)
- mem_busy_i  in  1  data bus not ready
- irq_req_i  in  1  CLINT interrupt pending (level)
- irq_addr_i  in  XLEN  trap vector
- jump_en_o  out  1  redirect to pc_reg
- jump_addr_o  out  XLEN  redirect target
- stall_pc_o, stall_if_id_o, stall_id_ex_o  out  1 each  hold stage register
- flush_if_id_o, flush_id_ex_o  out  1 each  insert bubble
- irq_ack_o  out  1  interrupt taken (one-cycle pulse)
- irq_epc_o  out  XLEN  resume PC latched at entry
- div_timeout_o  out  1  sticky divider timeout flag

Behaviour:
- Outputs are combinational from the registered state plus current inputs. Registered items: state, irq_addr/epc latches, div counter, timeout flag.
- Reset (async, rst_n=0): state=RUN, counter=0, div_timeout_o=0, irq_epc_o=0, latches=0. All stall/flush/jump/ack outputs are 0 while in reset.
- States: RUN, DIV_WAIT, IRQ_DRAIN, IRQ_JUMP.
- RUN, evaluated in strict priority order (only the first matching rule applies):
  1. jump_en_i: jump_en_o=1, jump_addr_o=jump_addr_i, flush_if_id=1, flush_id_ex=1. Any div_start/irq this cycle is ignored; irq is re-seen next cycle.
  2. mem_busy_i: stall pc, if_id and id_ex; no flush.
  3. div_start_i: stall pc, if_id and id_ex; counter<=0; go DIV_WAIT. irq is deferred.
  4. irq_req_i: latch irq_addr_i and irq_epc<=id_pc_i; stall pc and if_id; flush id_ex; go IRQ_DRAIN.
  5. Load-use (ex_is_load_i && ex_rd_i!=0 && ((id_rs1_used_i && id_rs1_i==ex_rd_i) || (id_rs2_used_i && id_rs2_i==ex_rd_i))): stall pc and if_id; flush id_ex.
  6. Otherwise all outputs 0.
- DIV_WAIT:
  - Stall pc, if_id and id_ex; counter increments each cycle; jump_en_i and irq_req_i are ignored.
  - div_done_i: stalls deasserted in that same cycle; go RUN.
  - Otherwise, counter==DIV_TIMEOUT-1: set div_timeout_o (sticky until reset); stalls deasserted; go RUN.
- IRQ_DRAIN:
  - Stall pc and if_id; flush id_ex.
  - mem_busy_i=0: go IRQ_JUMP. Otherwise remain.
  - irq_req_i dropping here does not abort entry.
- IRQ_JUMP (exactly one cycle):
  - jump_en_o=1, jump_addr_o=latched vector, flush_if_id=1, flush_id_ex=1, irq_ack_o=1, irq_epc_o valid; go RUN.
- Outside IRQ_JUMP, jump_addr_o = jump_addr_i.
- Counter width: $clog2(DIV_TIMEOUT)+1; it never wraps.
- A flush and a stall on the same stage register never assert together. A flush of id_ex overrides any stall of id_ex.

Decomposition:
- pipe_flow_pkg: state enum (2-bit), DIV_TIMEOUT default, REG_X0 constant.
- Sub-module hazard_unit: combinational load-use compare, output load_use_o.

Test Plan:
- Load x5 in EX, ID add reads rs1=x5 (used) -> one cycle stall_pc=stall_if_id=flush_id_ex=1. Same case with ex_rd=0 -> no stall.
- jump_en_i=1, jump_addr=0x0000_0100, with irq_req_i=1 the same cycle -> jump_en_o=1, addr 0x100, both flushes, no ack. The next cycle enters IRQ_DRAIN.
- irq_req_i=1, irq_addr=0x8000_0000, id_pc=0x0000_0040, mem_busy=1 for 3 cycles -> drain 3 cycles. Then an IRQ_JUMP cycle with jump to 0x8000_0000, irq_ack_o pulse, irq_epc_o=0x40.
- div_start_i, div_done_i after 33 cycles -> all stalls high 33 cycles and deasserted in the done cycle; irq raised mid-divide is taken only after return to RUN.
- div_start_i with no div_done_i -> after 40 cycles div_timeout_o=1 sticky, state RUN.
- rst_n pulled low in IRQ_DRAIN -> immediate all-zero outputs; after release, state RUN and no irq_ack_o.
